// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Control FSM for a multi-cycle MIPS datapath. Sequences
//            FETCH/DECODE/EXECUTE/MEM/WRITEBACK for R-type, LW, SW, BEQ,
//            BNE and J over one shared memory port with a ready handshake,
//            a wait-state timeout and a sticky FAULT state.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            opcode_i         - IR[31:26], valid from the cycle after ir_write
//            mem_ready_i      - memory done/accepted this cycle
//            zero_i           - ALU zero flag
//            ir_write_o, pc_write_o, pc_src_o, i_or_d_o, mem_req_o,
//            mem_we_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o,
//            alu_src_b_o, alu_op_o - datapath controls
//            retire_o         - pulse on the last cycle of each instruction
//            illegal_o        - pulse in DECODE on an unsupported opcode
//            fault_o          - sticky memory timeout, cleared only by rst
//            state_o          - current state encoding (debug)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TO_W        = 4,
    parameter bit          ENABLE_BNE  = 1'b1,
    parameter bit          ENABLE_J    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    input  logic       zero_i,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic [1:0] pc_src_o,
    output logic       i_or_d_o,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic       retire_o,
    output logic       illegal_o,
    output logic       fault_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_FAULT  = 4'd15
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [2:0] c_ALU_ADD   = 3'b001;
    localparam logic [2:0] c_ALU_SUB   = 3'b010;
    localparam logic [2:0] c_ALU_FUNCT = 3'b100;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              w_mem_state;
    logic              w_to_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Wait-state counter: it only runs while a memory state waits on ready.
    // Leaving the memory states clears it, which also covers every re-entry.
    always_comb begin
        w_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                      (state_q == S_MEMWR);
        // The current low-ready cycle would be wait number to_cnt_q+1.
        w_to_hit    = (MEM_TIMEOUT != 0) &&
                      ((32'(to_cnt_q) + 32'd1) == MEM_TIMEOUT);
        to_cnt_d    = to_cnt_q;
        if (!w_mem_state || mem_ready_i) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != '1) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 2'b00;
        i_or_d_o     = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 3'b000;
        retire_o     = 1'b0;
        illegal_o    = 1'b0;
        fault_o      = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = 2'b01;
                alu_op_o    = c_ALU_ADD;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_DECODE;
                end else if (w_to_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                alu_src_b_o = 2'b11;
                alu_op_o    = c_ALU_ADD;
                case (opcode_i)
                    c_OP_LW, c_OP_SW: state_d = S_MEMADR;
                    c_OP_RTYPE:       state_d = S_EXEC;
                    c_OP_BEQ:         state_d = S_BRANCH;
                    c_OP_BNE: begin
                        if (ENABLE_BNE) begin
                            state_d = S_BRANCH;
                        end else begin
                            illegal_o = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                    c_OP_J: begin
                        if (ENABLE_J) begin
                            state_d = S_JUMP;
                        end else begin
                            illegal_o = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_o = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = c_ALU_ADD;
                state_d     = (opcode_i == c_OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req_o = 1'b1;
                i_or_d_o  = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_MEMWB;
                end else if (w_to_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                retire_o     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                i_or_d_o  = 1'b1;
                if (mem_ready_i) begin
                    retire_o = 1'b1;
                    state_d  = S_FETCH;
                end else if (w_to_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = c_ALU_FUNCT;
                state_d     = S_RWB;
            end
            S_RWB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                retire_o    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = c_ALU_SUB;
                pc_src_o    = 2'b01;
                // opcode[0] distinguishes BNE from BEQ and inverts the test.
                pc_write_o  = zero_i ^ opcode_i[0];
                retire_o    = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_src_o   = 2'b10;
                pc_write_o = 1'b1;
                retire_o   = 1'b1;
                state_d    = S_FETCH;
            end
            S_FAULT: begin
                fault_o = 1'b1;
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        state_o = state_q;

        // No datapath writes may happen in a reset cycle, whatever the state.
        if (rst) begin
            ir_write_o   = 1'b0;
            pc_write_o   = 1'b0;
            pc_src_o     = 2'b00;
            i_or_d_o     = 1'b0;
            mem_req_o    = 1'b0;
            mem_we_o     = 1'b0;
            reg_dst_o    = 1'b0;
            mem_to_reg_o = 1'b0;
            reg_write_o  = 1'b0;
            alu_src_a_o  = 1'b0;
            alu_src_b_o  = 2'b00;
            alu_op_o     = 3'b000;
            retire_o     = 1'b0;
            illegal_o    = 1'b0;
            fault_o      = 1'b0;
            state_o      = 4'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed self-checking bench for multicycle_control. A second
//            instance built with ENABLE_J=0 shares the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       zero;

    logic       ir_write, pc_write, i_or_d, mem_req, mem_we, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a, retire, illegal, fault;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;

    logic       nj_ir_write, nj_pc_write, nj_i_or_d, nj_mem_req, nj_mem_we;
    logic       nj_reg_dst, nj_mem_to_reg, nj_reg_write, nj_alu_src_a;
    logic       nj_retire, nj_illegal, nj_fault;
    logic [1:0] nj_pc_src, nj_alu_src_b;
    logic [2:0] nj_alu_op;
    logic [3:0] nj_state;

    int n_checks = 0;
    int n_fail   = 0;
    int ret_cnt  = 0;
    int ret_base;

    always #5 clk = ~clk;

    multicycle_control u_dut (
        .clk          (clk),
        .rst          (rst),
        .opcode_i     (opcode),
        .mem_ready_i  (mem_ready),
        .zero_i       (zero),
        .ir_write_o   (ir_write),
        .pc_write_o   (pc_write),
        .pc_src_o     (pc_src),
        .i_or_d_o     (i_or_d),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .reg_write_o  (reg_write),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .alu_op_o     (alu_op),
        .retire_o     (retire),
        .illegal_o    (illegal),
        .fault_o      (fault),
        .state_o      (state)
    );

    multicycle_control #(.ENABLE_J(1'b0)) u_dut_nj (
        .clk          (clk),
        .rst          (rst),
        .opcode_i     (opcode),
        .mem_ready_i  (mem_ready),
        .zero_i       (zero),
        .ir_write_o   (nj_ir_write),
        .pc_write_o   (nj_pc_write),
        .pc_src_o     (nj_pc_src),
        .i_or_d_o     (nj_i_or_d),
        .mem_req_o    (nj_mem_req),
        .mem_we_o     (nj_mem_we),
        .reg_dst_o    (nj_reg_dst),
        .mem_to_reg_o (nj_mem_to_reg),
        .reg_write_o  (nj_reg_write),
        .alu_src_a_o  (nj_alu_src_a),
        .alu_src_b_o  (nj_alu_src_b),
        .alu_op_o     (nj_alu_op),
        .retire_o     (nj_retire),
        .illegal_o    (nj_illegal),
        .fault_o      (nj_fault),
        .state_o      (nj_state)
    );

    // Retire pulses are counted once per cycle on the falling edge.
    always @(negedge clk) begin
        if (retire === 1'b1) ret_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change at posedge+1; outputs are sampled at posedge+4.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        adv();
        adv();
        rst = 1'b0;
    endtask

    // FETCH (ready) -> DECODE -> BRANCH, checking the branch decision.
    task automatic run_branch(input string tag, input logic [5:0] opc,
                              input logic z, input logic exp_pcw);
        opcode    = opc;
        zero      = z;
        mem_ready = 1'b1;
        settle(); check_eq({tag, "_fetch_state"}, 32'(state), 32'd0);
        adv();
        settle(); check_eq({tag, "_decode_state"}, 32'(state), 32'd1);
        adv();
        settle();
        check_eq({tag, "_branch_state"}, 32'(state), 32'd8);
        check_eq({tag, "_pc_write"}, 32'(pc_write), 32'(exp_pcw));
        check_eq({tag, "_pc_src"}, 32'(pc_src), 32'd1);
        check_eq({tag, "_alu_op"}, 32'(alu_op), 32'd2);
        check_eq({tag, "_retire"}, 32'(retire), 32'd1);
        adv();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] lw_st [8];
        logic       lw_rdy[8];
        lw_st  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        lw_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 6'b000000;

        // Reset: everything quiet.
        adv(); settle();
        check_eq("rst_state",    32'(state),    32'd0);
        check_eq("rst_mem_req",  32'(mem_req),  32'd0);
        check_eq("rst_ir_write", 32'(ir_write), 32'd0);
        check_eq("rst_pc_write", 32'(pc_write), 32'd0);
        check_eq("rst_fault",    32'(fault),    32'd0);
        adv();
        rst = 1'b0;

        // R-type: 0,1,6,7 then FETCH, one retire.
        ret_base = ret_cnt;
        settle();
        check_eq("r_fetch_state", 32'(state),     32'd0);
        check_eq("r_ir_write",    32'(ir_write),  32'd1);
        check_eq("r_pc_write",    32'(pc_write),  32'd1);
        check_eq("r_mem_req",     32'(mem_req),   32'd1);
        check_eq("r_alu_src_b",   32'(alu_src_b), 32'd1);
        check_eq("r_fetch_aluop", 32'(alu_op),    32'd1);
        adv(); settle();
        check_eq("r_decode_state", 32'(state),     32'd1);
        check_eq("r_decode_srcb",  32'(alu_src_b), 32'd3);
        adv(); settle();
        check_eq("r_exec_state", 32'(state),     32'd6);
        check_eq("r_exec_aluop", 32'(alu_op),    32'd4);
        check_eq("r_exec_srca",  32'(alu_src_a), 32'd1);
        adv(); settle();
        check_eq("r_rwb_state",     32'(state),     32'd7);
        check_eq("r_rwb_reg_dst",   32'(reg_dst),   32'd1);
        check_eq("r_rwb_reg_write", 32'(reg_write), 32'd1);
        check_eq("r_rwb_retire",    32'(retire),    32'd1);
        adv(); settle();
        check_eq("r_back_fetch", 32'(state), 32'd0);
        check_eq("r_retire_cnt", 32'(ret_cnt - ret_base), 32'd1);
        do_reset();

        // LW with three wait states in MEMRD: 8 cycles.
        opcode = 6'b100011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = lw_rdy[i];
            settle();
            check_eq($sformatf("lw_state_c%0d", i), 32'(state), 32'(lw_st[i]));
            if (i == 7) begin
                check_eq("lw_wb_reg_write",  32'(reg_write),  32'd1);
                check_eq("lw_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
                check_eq("lw_wb_retire",     32'(retire),     32'd1);
            end
            adv();
        end
        mem_ready = 1'b1;

        // Branches.
        run_branch("bne_z1", 6'b000101, 1'b1, 1'b0);
        run_branch("beq_z1", 6'b000100, 1'b1, 1'b1);
        run_branch("beq_z0", 6'b000100, 1'b0, 1'b0);
        run_branch("bne_z0", 6'b000101, 1'b0, 1'b1);

        // Illegal opcode 111111.
        opcode = 6'b111111;
        ret_base = ret_cnt;
        settle(); check_eq("ill_fetch_state", 32'(state), 32'd0);
        adv(); settle();
        check_eq("ill_decode_state", 32'(state),   32'd1);
        check_eq("ill_pulse",        32'(illegal), 32'd1);
        adv(); settle();
        check_eq("ill_back_fetch", 32'(state),   32'd0);
        check_eq("ill_pulse_gone", 32'(illegal), 32'd0);
        check_eq("ill_no_retire",  32'(ret_cnt - ret_base), 32'd0);
        do_reset();

        // J: legal on the main instance, illegal with ENABLE_J=0.
        opcode = 6'b000010;
        settle(); check_eq("j_fetch_state", 32'(state), 32'd0);
        adv(); settle();
        check_eq("j_decode_illegal",  32'(illegal),    32'd0);
        check_eq("nj_decode_state",   32'(nj_state),   32'd1);
        check_eq("nj_decode_illegal", 32'(nj_illegal), 32'd1);
        check_eq("nj_decode_retire",  32'(nj_retire),  32'd0);
        adv(); settle();
        check_eq("j_jump_state",    32'(state),      32'd9);
        check_eq("j_pc_write",      32'(pc_write),   32'd1);
        check_eq("j_pc_src",        32'(pc_src),     32'd2);
        check_eq("j_retire",        32'(retire),     32'd1);
        check_eq("nj_back_fetch",   32'(nj_state),   32'd0);
        check_eq("nj_illegal_gone", 32'(nj_illegal), 32'd0);
        do_reset();

        // SW with zero wait states: 0,1,2,5.
        opcode = 6'b101011;
        adv(); adv(); adv(); settle();
        check_eq("sw_memwr_state", 32'(state),    32'd5);
        check_eq("sw_mem_we",      32'(mem_we),   32'd1);
        check_eq("sw_i_or_d",      32'(i_or_d),   32'd1);
        check_eq("sw_retire",      32'(retire),   32'd1);
        adv();

        // SW interrupted by reset in MEMWR while ready.
        adv(); adv(); adv();
        rst = 1'b1;
        settle();
        check_eq("swrst_mem_req", 32'(mem_req), 32'd0);
        check_eq("swrst_mem_we",  32'(mem_we),  32'd0);
        check_eq("swrst_retire",  32'(retire),  32'd0);
        adv();
        rst = 1'b0;
        settle();
        check_eq("swrst_state", 32'(state), 32'd0);
        check_eq("swrst_fault", 32'(fault), 32'd0);
        do_reset();

        // Timeout: 15 low-ready cycles in FETCH -> FAULT.
        mem_ready = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            settle();
            check_eq($sformatf("to_wait_state_c%0d", k), 32'(state), 32'd0);
            adv();
        end
        settle();
        check_eq("to_fault_state", 32'(state),   32'd15);
        check_eq("to_fault_flag",  32'(fault),   32'd1);
        check_eq("to_fault_req",   32'(mem_req), 32'd0);
        mem_ready = 1'b1;
        adv(); settle();
        check_eq("to_fault_sticky_state", 32'(state), 32'd15);
        check_eq("to_fault_sticky_flag",  32'(fault), 32'd1);
        rst = 1'b1;
        adv();
        rst = 1'b0;
        settle();
        check_eq("to_rst_state", 32'(state), 32'd0);
        check_eq("to_rst_fault", 32'(fault), 32'd0);
        do_reset();

        // Ready arriving on the 15th wait cycle wins.
        mem_ready = 1'b0;
        for (int k = 1; k <= 14; k++) adv();
        mem_ready = 1'b1;
        settle();
        check_eq("to_edge_state",    32'(state),    32'd0);
        check_eq("to_edge_ir_write", 32'(ir_write), 32'd1);
        adv(); settle();
        check_eq("to_edge_decode", 32'(state), 32'd1);
        check_eq("to_edge_fault",  32'(fault), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
